num_entry: RTL and testbench
============================

// Module: num_entry
// PURPOSE
//  Sequential keypad digit-entry assembler: takes decimal key codes one per handshake,
//  builds a signed MAX_DIGITS-digit number, and on ENTER presents it as W-bit two's
//  complement plus digit/sign fields. Input side of the calculator, in front of
//  calc_mul/calc_div operands. No divider: digits are kept as BCD, binary is built at ENTER.
// PARAMETERS
//  W          8  output value width; must hold +/-(10^MAX_DIGITS - 1)
//  MAX_DIGITS 2  max magnitude digits per entry
// PORTS
//  clk        input   1  clock, all logic on posedge
//  rst_n      input   1  synchronous, active-HIGH reset (port name per codebase)
//  key_valid  input   1  key_code valid this cycle
//  key_code   input   4  0-9 digit, 0xA MINUS, 0xB CLEAR, 0xC ENTER, 0xD BKSP, 0xE/0xF invalid
//  key_ready  output  1  block accepts a key (key_valid & key_ready = accepted)
//  val_valid  output  1  result held and valid
//  val_ready  input   1  consumer takes result
//  value      output  W  two's-complement result
//  tens       output  4  BCD digit 1 (tens for MAX_DIGITS=2)
//  ones       output  4  BCD digit 0
//  neg        output  1  result negative
//  err        output  1  one-cycle pulse: accepted key rejected
// BEHAVIOUR
//  Reset: state=EMPTY, digit regs=0, cnt=0, sign=0; outputs: key_ready=1, val_valid=0,
//   value=0, tens=0, ones=0, neg=0, err=0. Reset wins over any same-cycle key/handshake.
//  States: EMPTY (cnt=0), ENTRY (0<cnt<MAX_DIGITS), FULL (cnt=MAX_DIGITS), DONE.
//  key_ready = 1 in EMPTY/ENTRY/FULL, 0 in DONE. Keys while key_ready=0 are dropped.
//  Accepted key at edge N updates state after edge N; err is high for the cycle after N.
//  Digit d: EMPTY/ENTRY -> shift digit array left, digit0=d, cnt+1; EMPTY->ENTRY,
//   ENTRY->FULL when cnt reaches MAX_DIGITS. FULL -> ignored, err. Leading 0 counts as digit.
//  MINUS: toggle sign in EMPTY/ENTRY/FULL; no state change.
//  CLEAR: from EMPTY/ENTRY/FULL -> EMPTY, digits=0, cnt=0, sign=0.
//  ENTER: from any non-DONE state -> DONE. value = sign ? -mag : mag, mag = sum digit_i*10^i
//   (x10 as (x<<3)+(x<<1), computed at width W). neg = sign & (mag!=0): no -0.
//   tens/ones = digit regs. EMPTY ENTER gives value 0, neg 0.
//  val_valid rises cycle after ENTER accepted, holds value/tens/ones/neg stable until
//   val_valid & val_ready; next cycle -> EMPTY, val_valid=0, key_ready=1, digit/sign regs
//   cleared; value/tens/ones/neg keep last result until next ENTER.
//  BKSP, 0xE, 0xF: ignored + err (when NUM_ENTRY_BKSP_EN undefined).
//  Only outputs value/tens/ones/neg/val_valid/key_ready/err are registered; no comb in->out path.
// CONFIGURATION
//  NUM_ENTRY_BKSP_EN defined: BKSP in ENTRY/FULL shifts digit array right (digit0 dropped,
//   top digit=0), cnt-1 (FULL->ENTRY; ENTRY->EMPTY when cnt hits 0, sign kept).
//   BKSP in EMPTY: ignored + err.
//  Undefined: 0xD treated as invalid (ignored + err); no backspace logic synthesized.
// TESTING
//  1 reset, keys 1,2,ENTER -> val_valid=1, value=8'd12, tens=1, ones=2, neg=0, err never high.
//  2 keys MINUS,4,7,ENTER, val_ready held 0 for 5 cycles -> value=8'hD1(-47), neg=1 stable;
//    keys during DONE see key_ready=0 and are dropped; val_ready=1 -> EMPTY next cycle.
//  3 keys 9,9,5 -> err pulse on 3rd digit; ENTER -> value=99. MINUS,ENTER from EMPTY -> 0,neg=0.
//  4 keys 3,CLEAR,8,ENTER -> value=8; keys 0xE,0xF -> err each, state unchanged.
//  5 rst_n=1 mid-entry after 5 and in DONE -> all outputs reset values next cycle.
//  6 NUM_ENTRY_BKSP_EN: 6,7,BKSP,2,ENTER -> value=62; BKSP in EMPTY -> err. Undefined: BKSP -> err, value=67.

Source files
------------

// File: rtl/num_entry_if.sv
// Keypad entry handshake bundle: key input channel and result output channel.
// The slave modport is the num_entry side; master is the keypad/consumer side.
interface num_entry_if #(
    parameter int unsigned W = 8
);
    logic         key_valid;
    logic [3:0]   key_code;
    logic         key_ready;
    logic         val_valid;
    logic         val_ready;
    logic [W-1:0] value;
    logic [3:0]   tens;
    logic [3:0]   ones;
    logic         neg;
    logic         err;

    modport master (
        output key_valid, key_code, val_ready,
        input  key_ready, val_valid, value, tens, ones, neg, err
    );

    modport slave (
        input  key_valid, key_code, val_ready,
        output key_ready, val_valid, value, tens, ones, neg, err
    );
endinterface

// File: rtl/num_entry.sv
// Keypad digit-entry assembler: collects BCD digits and a sign, emits a two's-complement value.
// Optional backspace support is enabled by defining NUM_ENTRY_BKSP_EN.
module num_entry #(
    parameter int unsigned W          = 8,
    parameter int unsigned MAX_DIGITS = 2
) (
    input logic        clk,
    input logic        rst_n,
    num_entry_if.slave bus
);
    localparam int unsigned     CntW    = $clog2(MAX_DIGITS + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(MAX_DIGITS);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam int unsigned     TensIdx = (MAX_DIGITS > 1) ? 1 : 0;

    localparam logic [3:0] KeyMinus = 4'hA;
    localparam logic [3:0] KeyClear = 4'hB;
    localparam logic [3:0] KeyEnter = 4'hC;
`ifdef NUM_ENTRY_BKSP_EN
    localparam logic [3:0] KeyBksp  = 4'hD;
`endif

    typedef enum logic [1:0] {StEmpty, StEntry, StFull, StDone} state_e;

    state_e          state_q;
    logic [3:0]      digits_q [MAX_DIGITS];
    logic [CntW-1:0] cnt_q;
    logic            sign_q;
    logic            key_ready_q;
    logic            val_valid_q;
    logic [W-1:0]    value_q;
    logic [3:0]      tens_q;
    logic [3:0]      ones_q;
    logic            neg_q;
    logic            err_q;

    logic [W-1:0]    mag_d;
    logic [W-1:0]    value_d;
    logic            neg_d;
    logic [3:0]      tens_d;
    logic            key_digit;

    assign key_digit = (bus.key_code <= 4'd9);

    // Binary magnitude by Horner's rule over the BCD digits, x10 as shift-and-add.
    always_comb begin
        mag_d = '0;
        for (int i = int'(MAX_DIGITS) - 1; i >= 0; i--) begin
            mag_d = (mag_d << 3) + (mag_d << 1) + W'(digits_q[i]);
        end
        value_d = sign_q ? -mag_d : mag_d;
        neg_d   = sign_q && (mag_d != '0);
        tens_d  = (MAX_DIGITS > 1) ? digits_q[TensIdx] : 4'd0;
    end

    // The reset port is active-high despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= StEmpty;
            for (int i = 0; i < int'(MAX_DIGITS); i++) digits_q[i] <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            key_ready_q <= 1'b1;
            val_valid_q <= 1'b0;
            value_q     <= '0;
            tens_q      <= '0;
            ones_q      <= '0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (state_q == StDone) begin
                if (bus.val_ready) begin
                    state_q     <= StEmpty;
                    key_ready_q <= 1'b1;
                    val_valid_q <= 1'b0;
                    for (int i = 0; i < int'(MAX_DIGITS); i++) digits_q[i] <= '0;
                    cnt_q       <= '0;
                    sign_q      <= 1'b0;
                end
            end else if (bus.key_valid && key_ready_q) begin
                if (key_digit) begin
                    if (state_q == StFull) begin
                        err_q <= 1'b1;
                    end else begin
                        for (int i = int'(MAX_DIGITS) - 1; i > 0; i--) begin
                            digits_q[i] <= digits_q[i-1];
                        end
                        digits_q[0] <= bus.key_code;
                        cnt_q       <= cnt_q + CntOne;
                        state_q     <= (cnt_q + CntOne == CntMax) ? StFull : StEntry;
                    end
                end else begin
                    case (bus.key_code)
                        KeyMinus: sign_q <= ~sign_q;
                        KeyClear: begin
                            state_q <= StEmpty;
                            for (int i = 0; i < int'(MAX_DIGITS); i++) digits_q[i] <= '0;
                            cnt_q   <= '0;
                            sign_q  <= 1'b0;
                        end
                        KeyEnter: begin
                            state_q     <= StDone;
                            key_ready_q <= 1'b0;
                            val_valid_q <= 1'b1;
                            value_q     <= value_d;
                            tens_q      <= tens_d;
                            ones_q      <= digits_q[0];
                            neg_q       <= neg_d;
                        end
`ifdef NUM_ENTRY_BKSP_EN
                        KeyBksp: begin
                            if (state_q == StEmpty) begin
                                err_q <= 1'b1;
                            end else begin
                                for (int i = 0; i < int'(MAX_DIGITS) - 1; i++) begin
                                    digits_q[i] <= digits_q[i+1];
                                end
                                digits_q[MAX_DIGITS-1] <= '0;
                                cnt_q   <= cnt_q - CntOne;
                                state_q <= (cnt_q == CntOne) ? StEmpty : StEntry;
                            end
                        end
`endif
                        default: err_q <= 1'b1;
                    endcase
                end
            end
        end
    end

    assign bus.key_ready = key_ready_q;
    assign bus.val_valid = val_valid_q;
    assign bus.value     = value_q;
    assign bus.tens      = tens_q;
    assign bus.ones      = ones_q;
    assign bus.neg       = neg_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_num_entry.sv
// Bench for num_entry: directed key sequences plus random traffic against a digit-queue model.
module tb_num_entry;
    localparam int unsigned W         = 8;
    localparam int unsigned MaxDigits = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    num_entry_if #(.W(W)) bus ();

    num_entry #(.W(W), .MAX_DIGITS(MaxDigits)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: entered digits as a queue, most significant first.
    int m_q[$];
    bit m_sign, m_done, m_err, m_neg;
    int m_value, m_tens, m_ones;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit valid, input int code, input bit vready);
        int mag;
        m_err = 1'b0;
        if (rst) begin
            m_q.delete();
            m_sign = 0; m_done = 0; m_value = 0; m_tens = 0; m_ones = 0; m_neg = 0;
        end else if (m_done) begin
            if (vready) begin
                m_done = 0;
                m_q.delete();
                m_sign = 0;
            end
        end else if (valid) begin
            if (code <= 9) begin
                if (m_q.size() < MaxDigits) m_q.push_back(code);
                else m_err = 1;
            end else if (code == 10) begin
                m_sign = !m_sign;
            end else if (code == 11) begin
                m_q.delete();
                m_sign = 0;
            end else if (code == 12) begin
                mag = 0;
                foreach (m_q[i]) mag = mag * 10 + m_q[i];
                m_value = m_sign ? -mag : mag;
                m_neg   = m_sign && (mag != 0);
                m_ones  = (m_q.size() >= 1) ? m_q[m_q.size()-1] : 0;
                m_tens  = (m_q.size() >= 2) ? m_q[m_q.size()-2] : 0;
                m_done  = 1;
`ifdef NUM_ENTRY_BKSP_EN
            end else if (code == 13 && m_q.size() > 0) begin
                void'(m_q.pop_back());
`endif
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit valid, input logic [3:0] code, input bit vready);
        rst_n         = rst;
        bus.key_valid = valid;
        bus.key_code  = code;
        bus.val_ready = vready;
        @(posedge clk);
        model_step(rst, valid, int'(code), vready);
        #1;
        check_eq("key_ready", int'(bus.key_ready), int'(!m_done));
        check_eq("val_valid", int'(bus.val_valid), int'(m_done));
        check_eq("value",     int'(bus.value),     m_value & 8'hFF);
        check_eq("tens",      int'(bus.tens),      m_tens);
        check_eq("ones",      int'(bus.ones),      m_ones);
        check_eq("neg",       int'(bus.neg),       int'(m_neg));
        check_eq("err",       int'(bus.err),       int'(m_err));
    endtask

    task automatic key(input logic [3:0] code);
        cycle(1'b0, 1'b1, code, 1'b0);
    endtask

    task automatic idle(input int n, input bit vready);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0, vready);
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.val_ready = 1'b0;
        rst_n         = 1'b1;
        cycle(1'b1, 1'b1, 4'h5, 1'b1);

        // 1: positive two-digit entry
        key(4'h1); key(4'h2); key(4'hC);
        check_eq("t1_value", int'(bus.value), 12);
        check_eq("t1_tens",  int'(bus.tens), 1);
        check_eq("t1_ones",  int'(bus.ones), 2);
        idle(1, 1'b1);

        // 2: negative value held while consumer stalls; keys in DONE dropped
        key(4'hA); key(4'h4); key(4'h7); key(4'hC);
        check_eq("t2_value", int'(bus.value), 8'hD1);
        check_eq("t2_neg",   int'(bus.neg), 1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 4'h3, 1'b0);
        check_eq("t2_hold", int'(bus.value), 8'hD1);
        idle(1, 1'b1);
        check_eq("t2_release", int'(bus.key_ready), 1);

        // 3: overflow digit, then minus zero
        key(4'h9); key(4'h9); key(4'h5);
        key(4'hC);
        check_eq("t3_value", int'(bus.value), 99);
        idle(1, 1'b1);
        key(4'hA); key(4'hC);
        check_eq("t3_zero", int'(bus.value), 0);
        check_eq("t3_noneg", int'(bus.neg), 0);
        idle(1, 1'b1);

        // 4: clear and invalid codes
        key(4'h3); key(4'hB); key(4'h8); key(4'hE); key(4'hF); key(4'hC);
        check_eq("t4_value", int'(bus.value), 8);
        idle(1, 1'b1);

        // 5: reset mid-entry and in DONE
        key(4'h5);
        cycle(1'b1, 1'b1, 4'hC, 1'b0);
        key(4'h1); key(4'hC);
        cycle(1'b1, 1'b0, 4'h0, 1'b0);

        // 6: backspace (or invalid code when the feature is absent)
        key(4'h6); key(4'h7); key(4'hD); key(4'h2); key(4'hC);
`ifdef NUM_ENTRY_BKSP_EN
        check_eq("t6_value", int'(bus.value), 62);
`else
        check_eq("t6_value", int'(bus.value), 67);
`endif
        idle(1, 1'b1);
        key(4'hD);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] code;
            int r;
            r = $urandom_range(0, 9);
            code = (r < 6) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
            cycle(($urandom % 64) == 0, ($urandom % 4) != 0, code, ($urandom % 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
